// File: rtl/periph_hub_pkg.sv
// Shared address-map constants and register offsets for periph_hub.
// Region decode lives in addr[11:8]; only page 0 (addr[31:12]==0) is mapped.
package periph_hub_pkg;

    localparam int ADDR_W     = 32;
    localparam int PAGE_LSB   = 12;
    localparam int REGION_LSB = 8;
    localparam int REGION_W   = 4;
    localparam int OFF_LSB    = 2;
    localparam int OFF_W      = 2;
    localparam int MAX_NSLOT  = 8;
    localparam int MAX_NIRQ   = 16;

    localparam logic [REGION_W-1:0] REGION_SELF = 4'hF;

    typedef enum logic [OFF_W-1:0] {
        OFF_STATUS  = 2'd0,
        OFF_MASK    = 2'd1,
        OFF_RAW     = 2'd2,
        OFF_ERRADDR = 2'd3
    } reg_off_e;

endpackage

// File: rtl/hub_intc.sv
// Interrupt controller: edge-detected sticky STATUS with W1C, MASK, and a
// registered masked output.
module hub_intc
    import periph_hub_pkg::*;
#(
    parameter int NIRQ = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NIRQ-1:0] irq_i,
    input  logic            status_wr_i,
    input  logic            mask_wr_i,
    input  logic [NIRQ-1:0] wd_i,
    output logic [NIRQ-1:0] status_o,
    output logic [NIRQ-1:0] mask_o,
    output logic [NIRQ-1:0] ex_int_o
);

    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] blk_q, blk_d;
    logic [NIRQ-1:0] status_q, status_d;
    logic [NIRQ-1:0] mask_q, mask_d;
    logic [NIRQ-1:0] ex_int_q;
    logic [NIRQ-1:0] rise;

    // blk_q holds off lines that were already high during reset until they drop,
    // so a level carried through reset never counts as a fresh edge.
    always_comb begin
        rise     = irq_i & ~irq_q & ~blk_q;
        blk_d    = blk_q & irq_i;
        status_d = (status_q & ~(status_wr_i ? wd_i : '0)) | rise;
        mask_d   = mask_wr_i ? wd_i : mask_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q    <= '0;
            blk_q    <= irq_i;
            status_q <= '0;
            mask_q   <= '0;
            ex_int_q <= '0;
        end else begin
            irq_q    <= irq_i;
            blk_q    <= blk_d;
            status_q <= status_d;
            mask_q   <= mask_d;
            ex_int_q <= status_q & mask_q;
        end
    end

    assign status_o = status_q;
    assign mask_o   = mask_q;
    assign ex_int_o = ex_int_q;

endmodule

// File: rtl/periph_hub.sv
// Peripheral hub: address decode to NSLOT slaves, combinational read mux, and
// interrupt/error registers in region 0xF. Error capture built with PERIPH_HUB_ERRCAP_EN.
module periph_hub
    import periph_hub_pkg::*;
#(
    parameter int NSLOT = 4,
    parameter int NIRQ  = 4,
    parameter int DW    = 32
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                we,
    input  logic [31:0]         addr_dm,
    input  logic [DW-1:0]       wd_dm,
    output logic [DW-1:0]       rd_dm,
    output logic [NSLOT-1:0]    slot_we,
    output logic [31:0]         slot_a,
    output logic [DW-1:0]       slot_wd,
    input  logic [NSLOT*DW-1:0] slot_rd,
    input  logic [NIRQ-1:0]     irq_in,
    output logic [NIRQ-1:0]     ex_int,
    output logic                err
);

    if (DW != 32) begin : g_dw_chk
        $error("periph_hub: DW must be 32");
    end
    if (NSLOT < 1 || NSLOT > MAX_NSLOT) begin : g_nslot_chk
        $error("periph_hub: NSLOT out of range");
    end
    if (NIRQ < 1 || NIRQ > MAX_NIRQ) begin : g_nirq_chk
        $error("periph_hub: NIRQ out of range");
    end

    logic [REGION_W-1:0] region;
    reg_off_e            off;
    logic                page0;
    logic                self_hit;
    logic [NSLOT-1:0]    slot_sel;
    logic [NIRQ-1:0]     status, mask;
    logic [31:0]         erraddr;

    assign region   = addr_dm[REGION_LSB +: REGION_W];
    assign off      = reg_off_e'(addr_dm[OFF_LSB +: OFF_W]);
    assign page0    = (addr_dm[ADDR_W-1:PAGE_LSB] == '0);
    assign self_hit = page0 && (region == REGION_SELF);

    always_comb begin
        slot_sel = '0;
        for (int i = 0; i < NSLOT; i++) begin
            slot_sel[i] = page0 && (region == REGION_W'(i));
        end
    end

    assign slot_we = we ? slot_sel : '0;
    assign slot_a  = addr_dm;
    assign slot_wd = wd_dm;

    hub_intc #(
        .NIRQ(NIRQ)
    ) u_intc (
        .clk_i       (Clk),
        .rst_i       (Rst),
        .irq_i       (irq_in),
        .status_wr_i (we && self_hit && off == OFF_STATUS),
        .mask_wr_i   (we && self_hit && off == OFF_MASK),
        .wd_i        (wd_dm[NIRQ-1:0]),
        .status_o    (status),
        .mask_o      (mask),
        .ex_int_o    (ex_int)
    );

    always_comb begin
        rd_dm = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (slot_sel[i]) rd_dm = slot_rd[i*DW +: DW];
        end
        if (self_hit) begin
            case (off)
                OFF_STATUS:  rd_dm[NIRQ-1:0] = status;
                OFF_MASK:    rd_dm[NIRQ-1:0] = mask;
                OFF_RAW:     rd_dm[NIRQ-1:0] = irq_in;
                OFF_ERRADDR: rd_dm = DW'(erraddr);
                default:     rd_dm = '0;
            endcase
        end
    end

`ifdef PERIPH_HUB_ERRCAP_EN
    logic        err_q, err_d;
    logic [31:0] erraddr_q, erraddr_d;
    logic        unmapped;

    // First unmapped access wins; only a write to ERRADDR re-arms capture.
    always_comb begin
        unmapped  = ~(|slot_sel) & ~self_hit;
        err_d     = err_q;
        erraddr_d = erraddr_q;
        if (we && self_hit && off == OFF_ERRADDR) begin
            err_d = 1'b0;
        end else if (unmapped && !err_q) begin
            err_d     = 1'b1;
            erraddr_d = addr_dm;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            err_q     <= 1'b0;
            erraddr_q <= '0;
        end else begin
            err_q     <= err_d;
            erraddr_q <= erraddr_d;
        end
    end

    assign err     = err_q;
    assign erraddr = erraddr_q;
`else
    assign err     = 1'b0;
    assign erraddr = '0;
`endif

endmodule

// File: tb/tb_periph_hub.sv
// Randomised self-checking bench for periph_hub against a cycle-level reference
// model of the register map, interrupt edge rules and error capture.
module tb_periph_hub;

    localparam int NSLOT = 4;
    localparam int NIRQ  = 4;
    localparam int DW    = 32;

    logic                Clk = 1'b0;
    logic                Rst;
    logic                we;
    logic [31:0]         addr_dm;
    logic [DW-1:0]       wd_dm;
    logic [DW-1:0]       rd_dm;
    logic [NSLOT-1:0]    slot_we;
    logic [31:0]         slot_a;
    logic [DW-1:0]       slot_wd;
    logic [NSLOT*DW-1:0] slot_rd;
    logic [NIRQ-1:0]     irq_in;
    logic [NIRQ-1:0]     ex_int;
    logic                err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] slot_data [NSLOT];

    // reference model state
    logic [NIRQ-1:0] m_status, m_mask, m_ex;
    bit              m_prev [NIRQ];
    bit              m_held [NIRQ];
    bit              m_err;
    logic [31:0]     m_erraddr;

    periph_hub #(.NSLOT(NSLOT), .NIRQ(NIRQ), .DW(DW)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .we      (we),
        .addr_dm (addr_dm),
        .wd_dm   (wd_dm),
        .rd_dm   (rd_dm),
        .slot_we (slot_we),
        .slot_a  (slot_a),
        .slot_wd (slot_wd),
        .slot_rd (slot_rd),
        .irq_in  (irq_in),
        .ex_int  (ex_int),
        .err     (err)
    );

    always #5 Clk = ~Clk;

    always_comb begin
        slot_rd = '0;
        for (int i = 0; i < NSLOT; i++) slot_rd[i*DW +: DW] = slot_data[i];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        int r, o;
        r = int'(a[11:8]);
        o = int'(a[3:2]);
        if (a[31:12] != 20'd0) return 32'd0;
        if (r < NSLOT) return slot_data[r];
        if (r == 15) begin
            if (o == 0) return 32'(m_status);
            if (o == 1) return 32'(m_mask);
            if (o == 2) return 32'(irq_in);
            return m_erraddr;
        end
        return 32'd0;
    endfunction

    // Advance one clock: derive the model's next state from the inputs the DUT samples.
    task automatic tick();
        logic [NIRQ-1:0] ns, nm, nex;
        bit              np [NIRQ];
        bit              nh [NIRQ];
        bit              nerr;
        logic [31:0]     nea;
        int              r, o;
        bit              pg0, self_acc, mapped;
        r        = int'(addr_dm[11:8]);
        o        = int'(addr_dm[3:2]);
        pg0      = (addr_dm[31:12] == 20'd0);
        self_acc = pg0 && (r == 15);
        mapped   = self_acc || (pg0 && r < NSLOT);
        if (Rst) begin
            ns = '0; nm = '0; nex = '0; nerr = 1'b0; nea = '0;
            for (int k = 0; k < NIRQ; k++) begin
                np[k] = 1'b0;
                nh[k] = irq_in[k];
            end
        end else begin
            nex = m_status & m_mask;
            ns = m_status; nm = m_mask; nerr = m_err; nea = m_erraddr;
            if (we && self_acc && o == 0) ns = ns & ~wd_dm[NIRQ-1:0];
            if (we && self_acc && o == 1) nm = wd_dm[NIRQ-1:0];
            for (int k = 0; k < NIRQ; k++) begin
                if (irq_in[k] && !m_prev[k] && !m_held[k]) ns[k] = 1'b1;
                np[k] = irq_in[k];
                nh[k] = m_held[k] && irq_in[k];
            end
`ifdef PERIPH_HUB_ERRCAP_EN
            if (we && self_acc && o == 3) nerr = 1'b0;
            else if (!mapped && !m_err) begin
                nerr = 1'b1;
                nea  = addr_dm;
            end
`endif
        end
        @(posedge Clk);
        #1;
        m_status = ns; m_mask = nm; m_ex = nex; m_err = nerr; m_erraddr = nea;
        for (int k = 0; k < NIRQ; k++) begin
            m_prev[k] = np[k];
            m_held[k] = nh[k];
        end
    endtask

    task automatic test_reset();
        if (ex_int !== 4'h0) begin n_bad++; $display("FAIL reset_ex_int got %h exp 0", ex_int); end
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", err); end
        n_cmp++;
        addr_dm = 32'h0000_0F00; #1;
        if (rd_dm !== 32'h0) begin n_bad++; $display("FAIL reset_status got %h exp 0", rd_dm); end
        n_cmp++;
        addr_dm = 32'h0000_0F04; #1;
        if (rd_dm !== 32'h0) begin n_bad++; $display("FAIL reset_mask got %h exp 0", rd_dm); end
        n_cmp++;
        addr_dm = 32'h0000_0F0C; #1;
        if (rd_dm !== 32'h0) begin n_bad++; $display("FAIL reset_erraddr got %h exp 0", rd_dm); end
        n_cmp++;
        addr_dm = 32'h0;
    endtask

    task automatic test_decode();
        logic [NSLOT-1:0] exp_we;
        logic [31:0]      a;
        int               r;
        we = 1'b1; addr_dm = 32'h0000_0204; wd_dm = $urandom; #1;
        if (slot_we !== 4'b0100) begin n_bad++; $display("FAIL decode_we_204 got %b exp 0100", slot_we); end
        n_cmp++;
        if (slot_a !== 32'h204) begin n_bad++; $display("FAIL decode_a_204 got %h exp 204", slot_a); end
        n_cmp++;
        if (slot_wd !== wd_dm) begin n_bad++; $display("FAIL decode_wd got %h exp %h", slot_wd, wd_dm); end
        n_cmp++;
        addr_dm = 32'h0000_1204; #1;
        if (slot_we !== 4'b0000) begin n_bad++; $display("FAIL decode_we_1204 got %b exp 0000", slot_we); end
        n_cmp++;
        we = 1'b0; addr_dm = 32'h0;
        tick();
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 15);
            a = {($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'd0, 4'(r), 8'($urandom)};
            we = (r == 15) ? 1'b0 : 1'($urandom);
            addr_dm = a; wd_dm = $urandom; #1;
            exp_we = (we && a[31:12] == 20'd0 && r < NSLOT) ? NSLOT'(1 << r) : '0;
            if (slot_we !== exp_we) begin n_bad++; $display("FAIL decode_rand a=%h got %b exp %b", a, slot_we, exp_we); end
            n_cmp++;
            if (rd_dm !== exp_rd(a)) begin n_bad++; $display("FAIL decode_rd a=%h got %h exp %h", a, rd_dm, exp_rd(a)); end
            n_cmp++;
            tick();
        end
        we = 1'b0; addr_dm = 32'h0;
    endtask

    task automatic test_readmux();
        logic [31:0] a;
        slot_data[3] = 32'hDEAD_BEEF;
        we = 1'b0; addr_dm = 32'h0000_0300; #1;
        if (rd_dm !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rdmux_slot3 got %h exp deadbeef", rd_dm); end
        n_cmp++;
        addr_dm = 32'h0000_0500; #1;
        if (rd_dm !== 32'h0) begin n_bad++; $display("FAIL rdmux_unmapped got %h exp 0", rd_dm); end
        n_cmp++;
        addr_dm = 32'h0;
        tick();
        for (int n = 0; n < 30; n++) begin
            slot_data[$urandom_range(0, NSLOT-1)] = $urandom;
            irq_in = 4'($urandom);
            a = {($urandom_range(0, 4) == 0) ? 20'($urandom) : 20'd0, 4'($urandom), 8'($urandom)};
            addr_dm = a; #1;
            if (rd_dm !== exp_rd(a)) begin n_bad++; $display("FAIL rdmux_rand a=%h got %h exp %h", a, rd_dm, exp_rd(a)); end
            n_cmp++;
            tick();
        end
        addr_dm = 32'h0;
    endtask

    task automatic test_irq();
        irq_in = '0; tick(); tick();
        we = 1'b1; addr_dm = 32'h0000_0F00; wd_dm = 32'hF; tick();
        addr_dm = 32'h0000_0F04; wd_dm = 32'h5; tick();
        we = 1'b0; tick();
        irq_in = 4'h4; tick();
        irq_in = 4'h0; addr_dm = 32'h0000_0F00; #1;
        if (rd_dm !== 32'h4) begin n_bad++; $display("FAIL irq_status got %h exp 4", rd_dm); end
        n_cmp++;
        if (ex_int !== 4'h0) begin n_bad++; $display("FAIL irq_ex_lag got %h exp 0", ex_int); end
        n_cmp++;
        tick();
        if (ex_int !== 4'h4) begin n_bad++; $display("FAIL irq_ex got %h exp 4", ex_int); end
        n_cmp++;
        we = 1'b1; wd_dm = 32'h4; tick();
        we = 1'b0; #1;
        if (rd_dm !== 32'h0) begin n_bad++; $display("FAIL irq_w1c got %h exp 0", rd_dm); end
        n_cmp++;
        tick();
        if (ex_int !== 4'h0) begin n_bad++; $display("FAIL irq_ex_clr got %h exp 0", ex_int); end
        n_cmp++;
        irq_in = 4'h2; tick();
        we = 1'b1; wd_dm = 32'h2; tick();
        we = 1'b0; tick(); tick(); tick();
        if (rd_dm[1] !== 1'b0) begin n_bad++; $display("FAIL irq_level_held got %b exp 0", rd_dm[1]); end
        n_cmp++;
        irq_in = 4'h0; tick();
        irq_in = 4'h2; tick();
        if (rd_dm[1] !== 1'b1) begin n_bad++; $display("FAIL irq_reedge got %b exp 1", rd_dm[1]); end
        n_cmp++;
        irq_in = 4'($urandom); addr_dm = 32'h0000_0F08; #1;
        if (rd_dm !== 32'(irq_in)) begin n_bad++; $display("FAIL irq_raw got %h exp %h", rd_dm, irq_in); end
        n_cmp++;
        tick();
        irq_in = 4'h0; addr_dm = 32'h0; tick();
    endtask

    task automatic test_set_wins();
        irq_in = 4'h0; tick();
        irq_in = 4'h1; tick();
        irq_in = 4'h0; tick();
        irq_in = 4'h1; we = 1'b1; addr_dm = 32'h0000_0F00; wd_dm = 32'h1; tick();
        we = 1'b0; #1;
        if (rd_dm[0] !== 1'b1) begin n_bad++; $display("FAIL set_wins got %b exp 1", rd_dm[0]); end
        n_cmp++;
        if (rd_dm !== exp_rd(addr_dm)) begin n_bad++; $display("FAIL set_wins_model got %h exp %h", rd_dm, exp_rd(addr_dm)); end
        n_cmp++;
        irq_in = 4'h0; addr_dm = 32'h0; tick();
    endtask

    task automatic test_random_irq();
        int sel;
        for (int n = 0; n < 200; n++) begin
            irq_in = 4'($urandom);
            sel = $urandom_range(0, 7);
            we = (sel < 3);
            wd_dm = $urandom;
            addr_dm = (sel < 2) ? 32'h0000_0F00 : (sel == 2) ? 32'h0000_0F04 : {28'h0000_0F0, 2'($urandom_range(0, 2)), 2'b00};
            #1;
            if (rd_dm !== exp_rd(addr_dm)) begin n_bad++; $display("FAIL rand_rd n=%0d a=%h got %h exp %h", n, addr_dm, rd_dm, exp_rd(addr_dm)); end
            n_cmp++;
            tick();
            if (ex_int !== m_ex) begin n_bad++; $display("FAIL rand_ex n=%0d got %h exp %h", n, ex_int, m_ex); end
            n_cmp++;
        end
        we = 1'b0; irq_in = 4'h0; addr_dm = 32'h0; tick();
    endtask

    task automatic test_errcap();
        we = 1'b1; addr_dm = 32'h0000_0F0C; tick();
        we = 1'b0; addr_dm = 32'h0000_0700; tick();
        addr_dm = 32'h0000_0800; tick();
        addr_dm = 32'h0000_0F0C; #1;
`ifdef PERIPH_HUB_ERRCAP_EN
        if (err !== 1'b1) begin n_bad++; $display("FAIL errcap_set got %b exp 1", err); end
        n_cmp++;
        if (rd_dm !== 32'h700) begin n_bad++; $display("FAIL errcap_addr got %h exp 700", rd_dm); end
        n_cmp++;
        we = 1'b1; tick();
        we = 1'b0;
        if (err !== 1'b0) begin n_bad++; $display("FAIL errcap_clr got %b exp 0", err); end
        n_cmp++;
        addr_dm = 32'h0001_0000; tick();
        addr_dm = 32'h0000_0F0C; #1;
        if (rd_dm !== 32'h0001_0000) begin n_bad++; $display("FAIL errcap_rearm got %h exp 10000", rd_dm); end
        n_cmp++;
`else
        if (err !== 1'b0) begin n_bad++; $display("FAIL errcap_off_err got %b exp 0", err); end
        n_cmp++;
        if (rd_dm !== 32'h0) begin n_bad++; $display("FAIL errcap_off_addr got %h exp 0", rd_dm); end
        n_cmp++;
`endif
        if (err !== m_err) begin n_bad++; $display("FAIL errcap_model got %b exp %b", err, m_err); end
        n_cmp++;
        we = 1'b1; addr_dm = 32'h0000_0F0C; tick();
        we = 1'b0; addr_dm = 32'h0;
    endtask

    task automatic test_reset_mid();
        we = 1'b1; addr_dm = 32'h0000_0F04; wd_dm = 32'hF; tick();
        we = 1'b0; irq_in = 4'h0; tick();
        irq_in = 4'hF; tick();
        addr_dm = 32'h0000_0F00; tick();
        if (rd_dm !== 32'hF) begin n_bad++; $display("FAIL rstmid_pre_status got %h exp f", rd_dm); end
        n_cmp++;
        if (ex_int !== 4'hF) begin n_bad++; $display("FAIL rstmid_pre_ex got %h exp f", ex_int); end
        n_cmp++;
        Rst = 1'b1; we = 1'b1; addr_dm = 32'h0000_0F04; wd_dm = 32'hF; tick();
        Rst = 1'b0; we = 1'b0; addr_dm = 32'h0000_0F00;
        for (int n = 0; n < 4; n++) begin
            #1;
            if (rd_dm !== 32'h0) begin n_bad++; $display("FAIL rstmid_status n=%0d got %h exp 0", n, rd_dm); end
            n_cmp++;
            if (ex_int !== 4'h0) begin n_bad++; $display("FAIL rstmid_ex n=%0d got %h exp 0", n, ex_int); end
            n_cmp++;
            tick();
        end
        addr_dm = 32'h0000_0F04; #1;
        if (rd_dm !== 32'h0) begin n_bad++; $display("FAIL rstmid_mask got %h exp 0", rd_dm); end
        n_cmp++;
        irq_in = 4'h0; addr_dm = 32'h0000_0F00; tick();
        irq_in = 4'h1; tick();
        if (rd_dm !== 32'h1) begin n_bad++; $display("FAIL rstmid_newedge got %h exp 1", rd_dm); end
        n_cmp++;
        if (rd_dm !== exp_rd(addr_dm)) begin n_bad++; $display("FAIL rstmid_model got %h exp %h", rd_dm, exp_rd(addr_dm)); end
        n_cmp++;
    endtask

    initial begin
        Rst = 1'b1; we = 1'b0; addr_dm = 32'h0; wd_dm = '0; irq_in = '0;
        for (int i = 0; i < NSLOT; i++) slot_data[i] = $urandom;
        m_status = '0; m_mask = '0; m_ex = '0; m_err = 1'b0; m_erraddr = '0;
        for (int k = 0; k < NIRQ; k++) begin
            m_prev[k] = 1'b0;
            m_held[k] = 1'b0;
        end
        tick();
        tick();
        Rst = 1'b0;
        test_reset();
        test_decode();
        test_readmux();
        test_irq();
        test_set_wins();
        test_random_irq();
        test_errcap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
